logic_clock_domain_crossing_generic_read: RTL and testbench
===========================================================

# logic_clock_domain_crossing_generic_read

Read-side half of the generic dual-clock FIFO. Watches the write pointer already synchronized into its own clock domain, issues reads to the shared dual-port memory, and presents the returned words on an AXI4-Stream-style tx interface with full backpressure. A 2-entry output buffer absorbs the 1-cycle memory read latency so that one word per cycle is sustained while `tx_tready` stays high.

## Interface
- `DATA_WIDTH`, 1, width of stream and memory data.
- `ADDRESS_WIDTH`, 3, memory address and pointer width; must be ≥ 3, enforced by an elaboration DRC.
- `rx_aclk` input 1, clock of this block (read domain).
- `rx_areset_n` input 1, reset: asynchronous, active-low.
- `tx_tvalid` output 1, output word valid.
- `tx_tdata` output DATA_WIDTH, output word.
- `tx_tready` input 1, downstream accepts word.
- `read_enable` output 1, memory read strobe.
- `read_pointer` output ADDRESS_WIDTH, memory read address; also the pointer the writer side synchronizes.
- `read_data` input DATA_WIDTH, memory data; valid in the cycle after `read_enable`.
- `write_pointer_synced` input ADDRESS_WIDTH, writer's pointer, already synchronized into `rx_aclk`.

## Operation
- Pop: `pop = tx_tvalid && tx_tready`.
- `difference` register, ADDRESS_WIDTH bits, modulo 2^ADDRESS_WIDTH. Updated every cycle to `write_pointer_synced - (read_pointer + read_enable)`.
- `empty = (difference == 0)`.
- `inflight`: registered copy of `read_enable`.
- `count`: output buffer occupancy, 2 bits, range 0..2.
- Read issue: `read_enable = !empty && (count + inflight - pop) < 2`. Compute in 3-bit arithmetic so the subtraction cannot wrap.
- `read_pointer` increments by 1 on each `read_enable`. It wraps from 2^ADDRESS_WIDTH−1 to 0 naturally.
- Buffer push: in the cycle where `inflight` is high, `read_data` is written into the buffer.
- Buffer update when push and pop occur in the same cycle: `count` is unchanged and order is preserved.
- Buffer is FIFO-ordered. `tx_tdata` is always the head entry.
- `tx_tvalid = (count != 0)`. The output is registered, not derived combinationally from `read_data`.
- Handshake: once `tx_tvalid` is asserted, it and `tx_tdata` hold stable until `pop`.
- Lag on `write_pointer_synced` only delays reads; it never causes an over-read.
- Underflow of `difference` is illegal.
- Reset mid-operation: pointer, `difference`, `inflight` and `count` clear immediately. Buffered and in-flight words are discarded. The write side must be reset in the same window.

## Timing
- Reset values: `tx_tvalid`=0, `read_enable`=0, `read_pointer`=0.
- `tx_tdata` and buffer storage are not reset; their contents are don't-care while `tx_tvalid`=0.
- Latency from `write_pointer_synced` changing from equal to P+1 (edge e0):
  - `difference` updates at e1.
  - `read_enable` is high in cycle e1–e2.
  - `read_data` is valid in cycle e2–e3.
  - `tx_tvalid` rises after e3.
- Throughput: 1 word/cycle with `tx_tready`=1 and FIFO non-empty.
- Backpressure: after `tx_tready` drops, at most one further `read_enable` occurs, and the buffer saturates at 2.
- Resume: when `tx_tready` rises while `count`=2, reads restart in the same cycle as the first pop.

## Configuration
- Macro `LOGIC_CLOCK_DOMAIN_CROSSING_GENERIC_READ_ASSERTIONS_EN`.
- Defined: OVL fatal checkers are instantiated for three properties:
  - `difference` never transitions from '0 to '1 (underflow).
  - `count` never exceeds 2.
  - `tx_tdata` stays stable while `tx_tvalid && !tx_tready`.
- Undefined: no checker logic is elaborated and behaviour is identical.

## Structure
- Package `logic_clock_domain_crossing_pkg` holds:
  - `MIN_ADDRESS_WIDTH = 3`.
  - `OUTPUT_BUFFER_DEPTH = 2`.
  - typedef `count_t` (logic [1:0]).
- Sub-module `logic_clock_domain_crossing_generic_read_buffer` is the 2-entry valid/ready output buffer. It takes push/data in and exposes `count`, `tx_tvalid`, `tx_tdata`, `tx_tready`.
- The top level holds pointer, `difference` and read-issue logic.

## Test plan
- Reset: assert `rx_areset_n`=0 with `write_pointer_synced`=5 → `tx_tvalid`=0, `read_enable`=0, `read_pointer`=0. After release, reads begin at the second edge.
- Single word: `write_pointer_synced` 0→1 with memory[0]=0xA5 and `tx_tready`=1 → exactly one `read_enable`, `tx_tvalid` high 3 cycles after the change with `tx_tdata`=0xA5, then `read_pointer`=1 and `tx_tvalid`=0.
- Streaming: 8 words queued, `tx_tready`=1 → 8 consecutive pops with data in order, and no `read_enable` after `read_pointer` reaches 8 mod 8 = 0.
- Backpressure: 6 words queued, `tx_tready`=0 → `count` settles at 2 and `read_pointer`=2. Then raise `tx_tready` → words 0..5 are delivered with no gap or duplicate.
- Wrap-around (ADDRESS_WIDTH=3): 20 words pass while `write_pointer_synced` lags 2 cycles → `read_pointer` wraps 7→0 twice and the sequence is intact.
- Mid-stream reset with `count`=2 → `tx_tvalid` drops asynchronously and `read_pointer`=0. The first word after reset is memory[0].

Source files
------------

// File: rtl/logic_clock_domain_crossing_generic_read_pkg.sv
// -----------------------------------------------------------------------------
// logic_clock_domain_crossing_pkg
// Shared constants and types for the read half of the generic dual-clock FIFO.
//   MIN_ADDRESS_WIDTH   : smallest legal pointer width
//   OUTPUT_BUFFER_DEPTH : entries in the read-side output buffer
//   count_t             : output buffer occupancy (0..2)
//   buffer_demand()     : committed buffer slots once this cycle resolves
// -----------------------------------------------------------------------------
package logic_clock_domain_crossing_pkg;

  localparam int MIN_ADDRESS_WIDTH   = 3;
  localparam int OUTPUT_BUFFER_DEPTH = 2;

  typedef logic [1:0] count_t;

  // Words held plus the word coming back from memory, minus the word leaving.
  // Widened to 3 bits so the subtraction can never wrap.
  function automatic logic [2:0] buffer_demand(input count_t count,
                                               input logic   inflight,
                                               input logic   pop);
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/logic_clock_domain_crossing_generic_read_if.sv
// -----------------------------------------------------------------------------
// logic_clock_domain_crossing_generic_read_if
// Bundles the read block's stream output, memory read port and the
// synchronized write pointer.
//   master : the read block (drives tx_tvalid/tx_tdata, read_enable/read_pointer)
//   slave  : downstream sink, memory and write-pointer synchronizer
// -----------------------------------------------------------------------------
interface logic_clock_domain_crossing_generic_read_if #(
  parameter int DATA_WIDTH    = 1,
  parameter int ADDRESS_WIDTH = 3
);
  logic                     tx_tvalid;
  logic [DATA_WIDTH-1:0]    tx_tdata;
  logic                     tx_tready;
  logic                     read_enable;
  logic [ADDRESS_WIDTH-1:0] read_pointer;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [ADDRESS_WIDTH-1:0] write_pointer_synced;

  modport master (
    output tx_tvalid, tx_tdata, read_enable, read_pointer,
    input  tx_tready, read_data, write_pointer_synced
  );

  modport slave (
    input  tx_tvalid, tx_tdata, read_enable, read_pointer,
    output tx_tready, read_data, write_pointer_synced
  );
endinterface

// File: rtl/logic_clock_domain_crossing_generic_read_buffer.sv
// -----------------------------------------------------------------------------
// logic_clock_domain_crossing_generic_read_buffer
// Two-entry FIFO-ordered output buffer with registered valid/data.
//   rx_aclk, rx_areset_n : clock, asynchronous active-low reset
//   push, push_data      : word returned by memory this cycle
//   count                : occupancy 0..2
//   tx_tvalid, tx_tdata  : head of buffer (registered)
//   tx_tready            : downstream accept
// Storage is deliberately left unreset; only occupancy and valid clear.
// -----------------------------------------------------------------------------
module logic_clock_domain_crossing_generic_read_buffer
  import logic_clock_domain_crossing_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  rx_aclk,
  input  logic                  rx_areset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output count_t                count,
  output logic                  tx_tvalid,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  input  logic                  tx_tready
);

  count_t                count_r;
  count_t                count_next_s;
  logic                  valid_r;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;

  assign pop_s = valid_r && tx_tready;

  // Next occupancy from push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Occupancy and output valid, cleared asynchronously.
  always_ff @(posedge rx_aclk or negedge rx_areset_n) begin
    if (!rx_areset_n) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= (count_next_s != 2'd0);
    end
  end

  // Entry storage: head is always the oldest word, tail the second.
  always_ff @(posedge rx_aclk) begin
    case ({push, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          head_r <= push_data;
        end else begin
          tail_r <= push_data;
        end
      end
      2'b01: head_r <= tail_r;
      2'b11: begin
        if (count_r == 2'd1) begin
          head_r <= push_data;
        end else begin
          head_r <= tail_r;
          tail_r <= push_data;
        end
      end
      default: begin
        head_r <= head_r;
      end
    endcase
  end

  assign count     = count_r;
  assign tx_tvalid = valid_r;
  assign tx_tdata  = head_r;

endmodule

// File: rtl/logic_clock_domain_crossing_generic_read.sv
// -----------------------------------------------------------------------------
// logic_clock_domain_crossing_generic_read
// Read-side half of the generic dual-clock FIFO. Compares the synchronized
// write pointer with its own read pointer, issues memory reads and streams
// the returned words out through a 2-entry buffer that hides the 1-cycle
// memory latency.
//   rx_aclk     : read-domain clock
//   rx_areset_n : asynchronous active-low reset
//   rd_if       : master modport (tx stream, memory read port, write pointer)
// Optional build macro LOGIC_CLOCK_DOMAIN_CROSSING_GENERIC_READ_ASSERTIONS_EN
// instantiates OVL fatal checkers; without it no checker logic exists.
// -----------------------------------------------------------------------------
module logic_clock_domain_crossing_generic_read
  import logic_clock_domain_crossing_pkg::*;
#(
  parameter int DATA_WIDTH    = 1,
  parameter int ADDRESS_WIDTH = 3
) (
  input logic rx_aclk,
  input logic rx_areset_n,
  logic_clock_domain_crossing_generic_read_if.master rd_if
);

  if (ADDRESS_WIDTH < MIN_ADDRESS_WIDTH) begin : g_drc_address_width
    $error("ADDRESS_WIDTH must be at least %0d", MIN_ADDRESS_WIDTH);
  end

  logic [ADDRESS_WIDTH-1:0] difference_r;
  logic [ADDRESS_WIDTH-1:0] read_pointer_r;
  logic [ADDRESS_WIDTH-1:0] read_advance_s;
  logic                     inflight_r;
  logic                     pop_s;
  logic                     empty_s;
  logic                     read_enable_s;
  logic [2:0]               demand_s;
  count_t                   count_s;

  assign pop_s          = rd_if.tx_tvalid && rd_if.tx_tready;
  assign empty_s        = (difference_r == {ADDRESS_WIDTH{1'b0}});
  assign demand_s       = buffer_demand(count_s, inflight_r, pop_s);
  assign read_advance_s = {{(ADDRESS_WIDTH-1){1'b0}}, read_enable_s};

  // Issue a read only when a word is available and a buffer slot is free
  // once the in-flight word lands and any pop this cycle completes.
  always_comb begin
    read_enable_s = 1'b0;
    if (!empty_s && (demand_s < 3'(OUTPUT_BUFFER_DEPTH))) begin
      read_enable_s = 1'b1;
    end else begin
      read_enable_s = 1'b0;
    end
  end

  // Pointer, available-word count and memory latency tracking.
  // difference already accounts for the read issued this cycle, so a lagging
  // write pointer can only delay reads, never cause one past the writer.
  always_ff @(posedge rx_aclk or negedge rx_areset_n) begin
    if (!rx_areset_n) begin
      difference_r   <= {ADDRESS_WIDTH{1'b0}};
      read_pointer_r <= {ADDRESS_WIDTH{1'b0}};
      inflight_r     <= 1'b0;
    end else begin
      difference_r   <= rd_if.write_pointer_synced - (read_pointer_r + read_advance_s);
      read_pointer_r <= read_pointer_r + read_advance_s;
      inflight_r     <= read_enable_s;
    end
  end

  assign rd_if.read_enable  = read_enable_s;
  assign rd_if.read_pointer = read_pointer_r;

  logic_clock_domain_crossing_generic_read_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buffer (
    .rx_aclk     (rx_aclk),
    .rx_areset_n (rx_areset_n),
    .push        (inflight_r),
    .push_data   (rd_if.read_data),
    .count       (count_s),
    .tx_tvalid   (rd_if.tx_tvalid),
    .tx_tdata    (rd_if.tx_tdata),
    .tx_tready   (rd_if.tx_tready)
  );

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_GENERIC_READ_ASSERTIONS_EN
  localparam int OVL_SEVERITY_FATAL = 32'sd0;

  logic [ADDRESS_WIDTH-1:0] difference_prev_r;
  logic                     hold_prev_r;
  logic [DATA_WIDTH-1:0]    tdata_prev_r;

  // Previous-cycle history for the transition checkers.
  always_ff @(posedge rx_aclk or negedge rx_areset_n) begin
    if (!rx_areset_n) begin
      difference_prev_r <= {ADDRESS_WIDTH{1'b0}};
      hold_prev_r       <= 1'b0;
      tdata_prev_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      difference_prev_r <= difference_r;
      hold_prev_r       <= rd_if.tx_tvalid && !rd_if.tx_tready;
      tdata_prev_r      <= rd_if.tx_tdata;
    end
  end

  ovl_always #(.severity_level(OVL_SEVERITY_FATAL), .msg("difference underflow")) u_chk_underflow (
    .clock(rx_aclk), .reset(rx_areset_n), .enable(1'b1),
    .test_expr(!((difference_prev_r == {ADDRESS_WIDTH{1'b0}}) &&
                 (difference_r == {ADDRESS_WIDTH{1'b1}}))),
    .fire());

  ovl_always #(.severity_level(OVL_SEVERITY_FATAL), .msg("buffer count above 2")) u_chk_count (
    .clock(rx_aclk), .reset(rx_areset_n), .enable(1'b1),
    .test_expr(count_s <= 2'(OUTPUT_BUFFER_DEPTH)),
    .fire());

  ovl_always #(.severity_level(OVL_SEVERITY_FATAL), .msg("tx_tdata changed under backpressure")) u_chk_stable (
    .clock(rx_aclk), .reset(rx_areset_n), .enable(1'b1),
    .test_expr(!hold_prev_r || (rd_if.tx_tvalid && (rd_if.tx_tdata == tdata_prev_r))),
    .fire());
`endif

endmodule

// File: tb/tb_logic_clock_domain_crossing_generic_read.sv
// -----------------------------------------------------------------------------
// Bench for logic_clock_domain_crossing_generic_read (DATA_WIDTH=8,
// ADDRESS_WIDTH=3). A writer model fills a memory model and advances the
// synchronized write pointer (optionally lagged); a scoreboard queue holds
// the words made visible to the reader and every pop is compared against it.
// -----------------------------------------------------------------------------
module tb_logic_clock_domain_crossing_generic_read;

  logic rx_aclk;
  logic rx_areset_n;

  logic_clock_domain_crossing_generic_read_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) bus ();

  logic_clock_domain_crossing_generic_read #(
    .DATA_WIDTH    (8),
    .ADDRESS_WIDTH (3)
  ) dut (
    .rx_aclk     (rx_aclk),
    .rx_areset_n (rx_areset_n),
    .rd_if       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus controls (written only by the stimulus process)
  logic [7:0] words [64];
  int         wr_goal   = 0;
  logic       lag2      = 1'b0;
  logic       force_en  = 1'b0;
  logic [2:0] force_val = 3'd0;
  logic       mon_en    = 1'b0;

  // Model state (written only by the monitor/writer process)
  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int         wr_true = 0, wr_vis = 0, d1 = 0, d2 = 0, vis_new = 0;
  int         rd_total = 0, pops = 0, wraps = 0;
  int         wr_seen = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] last_pop = 8'd0;
  logic [7:0] exp_word;

  initial rx_aclk = 1'b0;
  always #5 rx_aclk = ~rx_aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: data appears the cycle after the read strobe.
  always @(posedge rx_aclk) begin
    if (bus.read_enable) bus.read_data <= mem[bus.read_pointer];
  end

  // Visible word count as of each active edge.
  always @(posedge rx_aclk) wr_seen <= wr_vis;

  // Compare process plus writer model, run on the inactive edge.
  always @(negedge rx_aclk) begin
    if (!rx_areset_n) begin
      exp_q.delete();
      wr_true = 0; wr_vis = 0; d1 = 0; d2 = 0;
      rd_total = 0; pops = 0; wraps = 0;
      prev_hold = 1'b0;
      bus.write_pointer_synced = force_en ? force_val : 3'd0;
    end else begin
      if (mon_en) begin
        if (prev_hold) begin
          check("hold_valid", bus.tx_tvalid, 1);
          check("hold_data", bus.tx_tdata, prev_data);
        end
        if (bus.tx_tvalid && bus.tx_tready) begin
          if (exp_q.size() == 0) begin
            check("pop_unexpected", pops, wr_vis);
          end else begin
            exp_word = exp_q.pop_front();
            check("pop_data", bus.tx_tdata, exp_word);
          end
          last_pop = bus.tx_tdata;
          pops++;
        end
        if (bus.read_enable) begin
          check("read_addr", bus.read_pointer, rd_total % 8);
          check("no_over_read", rd_total < wr_seen, 1);
          if (bus.read_pointer == 3'd7) wraps++;
          rd_total++;
        end
        prev_hold = bus.tx_tvalid && !bus.tx_tready;
        prev_data = bus.tx_tdata;
      end
      if (force_en) begin
        bus.write_pointer_synced = force_val;
      end else begin
        if (wr_true < wr_goal && (wr_true - rd_total) < 6) begin
          mem[wr_true % 8] = words[wr_true];
          wr_true++;
        end
        vis_new = lag2 ? d2 : wr_true;
        d2 = d1;
        d1 = wr_true;
        while (wr_vis < vis_new) begin
          exp_q.push_back(words[wr_vis]);
          wr_vis++;
        end
        bus.write_pointer_synced = 3'(wr_vis % 8);
      end
    end
  end

  task automatic cyc();
    @(posedge rx_aclk);
    #1;
  endtask

  task automatic do_reset();
    rx_areset_n = 1'b0;
    force_en = 1'b0;
    wr_goal = 0;
    lag2 = 1'b0;
    mon_en = 1'b1;
    cyc();
    cyc();
    rx_areset_n = 1'b1;
  endtask

  initial begin
    int n;
    rx_areset_n = 1'b0;
    bus.tx_tready = 1'b0;
    force_en = 1'b1;
    force_val = 3'd5;
    repeat (3) cyc();
    check("rst_tvalid", bus.tx_tvalid, 0);
    check("rst_read_enable", bus.read_enable, 0);
    check("rst_read_pointer", bus.read_pointer, 0);
    rx_areset_n = 1'b1;
    #1;
    check("rel_no_read_first", bus.read_enable, 0);
    cyc();
    check("rel_read_second", bus.read_enable, 1);

    // Single word
    do_reset();
    words[0] = 8'hA5;
    bus.tx_tready = 1'b1;
    wr_goal = 1;
    cyc();
    check("sw_read_enable", bus.read_enable, 1);
    check("sw_tvalid_early", bus.tx_tvalid, 0);
    cyc();
    check("sw_single_read", bus.read_enable, 0);
    check("sw_tvalid_e2", bus.tx_tvalid, 0);
    cyc();
    check("sw_tvalid", bus.tx_tvalid, 1);
    check("sw_tdata", bus.tx_tdata, 8'hA5);
    cyc();
    check("sw_tvalid_after", bus.tx_tvalid, 0);
    check("sw_read_pointer", bus.read_pointer, 1);
    repeat (3) cyc();
    check("sw_read_count", rd_total, 1);

    // Streaming 8 words
    do_reset();
    for (int k = 0; k < 8; k++) words[k] = 8'(k * 29 + 7);
    bus.tx_tready = 1'b1;
    wr_goal = 8;
    n = 0;
    do begin cyc(); n++; end while (!bus.tx_tvalid && n < 10);
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", bus.tx_tvalid, 1);
      cyc();
    end
    check("stream_end_valid", bus.tx_tvalid, 0);
    check("stream_pointer", bus.read_pointer, 0);
    check("stream_pops", pops, 8);
    for (int k = 0; k < 4; k++) begin
      check("stream_no_read", bus.read_enable, 0);
      cyc();
    end

    // Backpressure then resume
    do_reset();
    for (int k = 0; k < 6; k++) words[k] = 8'(8'h10 + k);
    bus.tx_tready = 1'b0;
    wr_goal = 6;
    repeat (12) cyc();
    check("bp_tvalid", bus.tx_tvalid, 1);
    check("bp_tdata", bus.tx_tdata, 8'h10);
    check("bp_pointer", bus.read_pointer, 2);
    check("bp_count", dut.count_s, 2);
    check("bp_no_read", bus.read_enable, 0);
    bus.tx_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("resume_valid", bus.tx_tvalid, 1);
      cyc();
    end
    check("resume_end_valid", bus.tx_tvalid, 0);
    check("resume_pops", pops, 6);
    check("resume_pointer", bus.read_pointer, 6);

    // Wrap-around with a 2-cycle lagging write pointer and bursty ready
    do_reset();
    lag2 = 1'b1;
    for (int k = 0; k < 20; k++) words[k] = 8'(8'h40 + k * 3);
    wr_goal = 20;
    n = 0;
    while (pops < 20 && n < 300) begin
      bus.tx_tready = (n % 3 != 2);
      cyc();
      n++;
    end
    bus.tx_tready = 1'b1;
    cyc();
    check("wrap_pops", pops, 20);
    check("wrap_count", wraps, 2);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_pointer", bus.read_pointer, 4);

    // Reset in the middle of a backpressured stream
    do_reset();
    for (int k = 0; k < 4; k++) words[k] = 8'(8'h80 + k);
    bus.tx_tready = 1'b0;
    wr_goal = 4;
    repeat (10) cyc();
    check("mr_count_before", dut.count_s, 2);
    check("mr_tvalid_before", bus.tx_tvalid, 1);
    #2;
    rx_areset_n = 1'b0;
    wr_goal = 0;
    #1;
    check("mr_tvalid_async", bus.tx_tvalid, 0);
    check("mr_pointer", bus.read_pointer, 0);
    check("mr_count", dut.count_s, 0);
    words[0] = 8'h5A;
    bus.tx_tready = 1'b1;
    cyc();
    cyc();
    rx_areset_n = 1'b1;
    wr_goal = 1;
    n = 0;
    while (pops < 1 && n < 20) begin cyc(); n++; end
    check("mr_pops", pops, 1);
    check("mr_first_word", last_pop, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
